// File: rtl/sample_serializer.sv
// Record FIFO plus byte-wide output stage: buffers capture records and presents
// them LSB-first on the sample/sample_rdy/sample_ack handshake, counting dropped records.
module sample_serializer #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [8*WORD_BYTES-1:0] rec_data,
   input  logic                    rec_wr,
   output logic                    rec_full,
   output logic [DEPTH_LOG2:0]     rec_level,
   output logic [15:0]             lost_count,
   input  logic                    lost_clr,
   output logic [7:0]              sample,
   output logic                    sample_rdy,
   input  logic                    sample_ack
);

   localparam int unsigned REC_W = 8 * WORD_BYTES;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
   localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   logic [REC_W-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  full_q, full_d;
   logic [15:0]           lost_q, lost_d;
   logic [REC_W-1:0]      shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  busy_q, busy_d;
   logic                  empty, push, drop, pop, last;

   // Next-state logic for FIFO pointers, occupancy, output stage and loss counter.
   always_comb begin
      empty    = (level_q == '0);
      push     = rec_wr & ~full_q;
      drop     = rec_wr & full_q;
      last     = (idx_q == IDX_W'(WORD_BYTES - 1));
      pop      = ~empty & (~busy_q | (sample_ack & last));

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      lost_d   = lost_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end

      // A pop on the last byte's ack reloads the stage with no idle cycle in between.
      if (pop) begin
         shift_d  = mem_q[rd_ptr_q];
         idx_d    = '0;
         busy_d   = 1'b1;
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end else if (busy_q && sample_ack) begin
         if (last) begin
            busy_d = 1'b0;
            idx_d  = '0;
         end else begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IDX_W'(1);
         end
      end

      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      full_d  = (level_d == LVL_W'(DEPTH));

      if (lost_clr) begin
         lost_d = drop ? 16'd1 : 16'd0;
      end else if (drop && (lost_q != 16'hFFFF)) begin
         lost_d = lost_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         lost_q   <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         lost_q   <= lost_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
      end
   end

   // Record storage needs no reset; occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rec_data;
      end
   end

   assign rec_full   = full_q;
   assign rec_level  = level_q;
   assign lost_count = lost_q;
   assign sample     = shift_q[7:0];
   assign sample_rdy = busy_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: latency, throughput, backpressure,
// overflow, loss-counter saturation/clear and mid-record reset.
module tb_sample_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rec_data;
   logic        rec_wr;
   logic        rec_full;
   logic [4:0]  rec_level;
   logic [15:0] lost_count;
   logic        lost_clr;
   logic [7:0]  sample;
   logic        sample_rdy;
   logic        sample_ack;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   sample_serializer #(.WORD_BYTES(4), .DEPTH_LOG2(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .rec_data   (rec_data),
      .rec_wr     (rec_wr),
      .rec_full   (rec_full),
      .rec_level  (rec_level),
      .lost_count (lost_count),
      .lost_clr   (lost_clr),
      .sample     (sample),
      .sample_rdy (sample_rdy),
      .sample_ack (sample_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      rec_wr     = 1'b0;
      lost_clr   = 1'b0;
      sample_ack = 1'b0;
      rec_data   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic write_rec(input logic [31:0] d);
      rec_data = d;
      rec_wr   = 1'b1;
      tick();
      rec_wr   = 1'b0;
   endtask

   // Expected wire order: byte 0 first.
   task automatic push_exp(input logic [31:0] d);
      for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
   endtask

   // Consume n bytes, acking every 'period' cycles; strict flags any gap once started.
   task automatic drain(input int n, input int period, input bit strict);
      int k = 0;
      bit started = 1'b0;
      for (int cyc = 0; cyc < 2000 && k < n; cyc++) begin
         sample_ack = ((cyc % period) == 0);
         if (sample_rdy) begin
            check("byte", 32'(sample), 32'(exp_q[k]));
            started = 1'b1;
            if (sample_ack) k++;
         end else if (strict && started) begin
            check("gap", 32'(sample_rdy), 32'd1);
         end
         tick();
      end
      sample_ack = 1'b0;
      check("drained", k, n);
      exp_q.delete();
   endtask

   initial begin
      do_reset();
      check("rst_sample", 32'(sample), 32'h0);
      check("rst_rdy",    32'(sample_rdy), 32'h0);
      check("rst_full",   32'(rec_full), 32'h0);
      check("rst_level",  32'(rec_level), 32'h0);
      check("rst_lost",   32'(lost_count), 32'h0);

      // Single record, ack held high, two-edge latency
      sample_ack = 1'b1;
      write_rec(32'hDDCCBBAA);
      check("lat_e0_rdy", 32'(sample_rdy), 32'h0);
      tick();
      check("lat_e1_rdy", 32'(sample_rdy), 32'h1);
      push_exp(32'hDDCCBBAA);
      drain(4, 1, 1'b1);
      check("single_idle", 32'(sample_rdy), 32'h0);
      check("single_level", 32'(rec_level), 32'h0);

      // Back-to-back records without a bubble
      sample_ack = 1'b1;
      rec_data = 32'h04030201; rec_wr = 1'b1; tick();
      rec_data = 32'h08070605; tick();
      rec_wr = 1'b0;
      check("b2b_rdy", 32'(sample_rdy), 32'h1);
      push_exp(32'h04030201);
      push_exp(32'h08070605);
      drain(8, 1, 1'b1);
      check("b2b_idle", 32'(sample_rdy), 32'h0);

      // Backpressure: ack every third cycle, bytes must hold
      write_rec(32'h44332211);
      push_exp(32'h44332211);
      drain(4, 3, 1'b0);
      check("bp_level", 32'(rec_level), 32'h0);
      check("bp_idle", 32'(sample_rdy), 32'h0);

      // Overflow: record 0 parks in the output stage, then 18 more writes
      write_rec(32'hA0000000);
      tick();
      push_exp(32'hA0000000);
      for (int i = 1; i <= 18; i++) begin
         rec_data = 32'hA0000000 + 32'(i);
         rec_wr   = 1'b1;
         tick();
         if (i == 16) begin
            check("ovf_full16",  32'(rec_full), 32'h1);
            check("ovf_level16", 32'(rec_level), 32'd16);
            check("ovf_lost16",  32'(lost_count), 32'd0);
         end
         if (i <= 16) push_exp(32'hA0000000 + 32'(i));
      end
      rec_wr = 1'b0;
      check("ovf_level", 32'(rec_level), 32'd16);
      check("ovf_lost",  32'(lost_count), 32'd2);
      drain(68, 1, 1'b1);
      check("ovf_empty", 32'(rec_level), 32'h0);
      check("ovf_notfull", 32'(rec_full), 32'h0);

      // Loss counter saturation
      write_rec(32'hB0000000);
      tick();
      for (int i = 1; i <= 16; i++) write_rec(32'hB0000000 + 32'(i));
      check("sat_full", 32'(rec_full), 32'h1);
      rec_wr = 1'b1;
      repeat (65537) tick();
      rec_wr = 1'b0;
      check("sat_lost", 32'(lost_count), 32'hFFFF);

      lost_clr = 1'b1; tick(); lost_clr = 1'b0;
      check("clr_lost", 32'(lost_count), 32'h0);
      lost_clr = 1'b1; rec_wr = 1'b1; tick();
      lost_clr = 1'b0; rec_wr = 1'b0;
      check("clr_drop_lost", 32'(lost_count), 32'h1);
      rec_wr = 1'b1; tick(); rec_wr = 1'b0;
      check("drop_after_clr", 32'(lost_count), 32'h2);

      // Reset mid-record with three records queued
      do_reset();
      rec_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rec_data = 32'hC3C2C1C0 + 32'(i * 16);
         tick();
      end
      rec_wr = 1'b0;
      check("mid_level", 32'(rec_level), 32'd3);
      sample_ack = 1'b1;
      tick();
      tick();
      sample_ack = 1'b0;
      check("mid_byte2", 32'(sample), 32'hC2);
      reset = 1'b1;
      #1;
      check("mid_rst_sample", 32'(sample), 32'h0);
      check("mid_rst_rdy",    32'(sample_rdy), 32'h0);
      check("mid_rst_level",  32'(rec_level), 32'h0);
      check("mid_rst_full",   32'(rec_full), 32'h0);
      check("mid_rst_lost",   32'(lost_count), 32'h0);
      do_reset();
      sample_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("no_stale", 32'(sample_rdy), 32'h0);
         tick();
      end
      write_rec(32'h5A6B7C8D);
      push_exp(32'h5A6B7C8D);
      drain(4, 1, 1'b1);
      check("post_rst_idle", 32'(sample_rdy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
